mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share one
// single-cycle memory port, one transaction in flight, round-robin on ties.
module mem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_resp_valid,
   input  logic                if_resp_ready,
   output logic [DATA_W-1:0]   if_rdata,

   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_we,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_resp_valid,
   input  logic                ls_resp_ready,
   output logic [DATA_W-1:0]   ls_rdata,

   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic                mem_ce,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   state_e              state_q,      state_d;
   owner_e              owner_q,      owner_d;
   owner_e              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic                we_q,         we_d;
   logic [DATA_W-1:0]   wdata_q,      wdata_d;
   logic [MASK_W-1:0]   wmask_q,      wmask_d;
   logic [DATA_W-1:0]   rdata_q,      rdata_d;

   logic grant_if;
   logic grant_ls;
   logic in_access;
   logic in_resp;
   logic owner_resp_ready;

   // Reset is folded into every output so nothing leaks out during the reset cycle.
   assign in_access = (state_q == S_ACCESS) && !reset;
   assign in_resp   = (state_q == S_RESP)   && !reset;

   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if ((state_q == S_IDLE) && !reset) begin
         if (if_req_valid && ls_req_valid) begin
            grant_if = (last_grant_q == OWN_LS);
            grant_ls = (last_grant_q == OWN_IF);
         end else begin
            grant_if = if_req_valid;
            grant_ls = ls_req_valid;
         end
      end
   end

   assign if_req_ready = grant_if;
   assign ls_req_ready = grant_ls;

   // The non-owner's resp_ready never influences the FSM.
   assign owner_resp_ready = (owner_q == OWN_IF) ? if_resp_ready : ls_resp_ready;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rdata_d      = rdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (grant_if) begin
               owner_d      = OWN_IF;
               last_grant_d = OWN_IF;
               addr_d       = if_addr;
               we_d         = 1'b0;
               wdata_d      = '0;
               wmask_d      = '0;
               state_d      = S_ACCESS;
            end else if (grant_ls) begin
               owner_d      = OWN_LS;
               last_grant_d = OWN_LS;
               addr_d       = ls_addr;
               we_d         = ls_we;
               wdata_d      = ls_wdata;
               wmask_d      = ls_wmask;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            rdata_d = we_q ? '0 : mem_rdata;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (owner_resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_LS;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_ce    = in_access;
   assign mem_we    = in_access && we_q;
   assign mem_addr  = in_access ? addr_q  : '0;
   assign mem_wdata = in_access ? wdata_q : '0;
   assign mem_wmask = in_access ? wmask_q : '0;

   assign if_resp_valid = in_resp && (owner_q == OWN_IF);
   assign ls_resp_valid = in_resp && (owner_q == OWN_LS);
   assign if_rdata      = if_resp_valid ? rdata_q : '0;
   assign ls_rdata      = ls_resp_valid ? rdata_q : '0;

endmodule
